// File: rtl/key_dir_arbiter.sv
// Keyboard-report to single-direction arbiter for the ball motion block.
// Latches key state per report, resolves it once per VGA frame on vs rise.
module key_dir_arbiter #(
   parameter logic [7:0] KEY_W = 8'h1A,
   parameter logic [7:0] KEY_A = 8'h04,
   parameter logic [7:0] KEY_S = 8'h16,
   parameter logic [7:0] KEY_D = 8'h07
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       report_valid,
   input  logic [7:0] key0,
   input  logic [7:0] key1,
   input  logic [7:0] key2,
   input  logic [7:0] key3,
   input  logic       vs,
   output logic [7:0] keycode,
   output logic       frame_tick,
   output logic [7:0] hold_frames
);

   // direction vectors are {W,A,S,D}; active/tap are one-hot, zero = invalid
   logic [3:0] pressed_q, pressed_d;
   logic [3:0] active_q, active_d;
   logic [3:0] tap_q, tap_d;
   logic [7:0] keycode_q, keycode_d;
   logic [7:0] hold_q, hold_d;
   logic       frame_tick_q, frame_tick_d;
   logic       vs_q, vs_d;
   logic       armed_q, armed_d;

   logic       rollover;
   logic       tick;
   logic       tap_set;
   logic [3:0] pressed_nx;
   logic [3:0] newly;
   logic [7:0] kc_nx;

   function automatic logic [3:0] pick(input logic [3:0] v);
      logic [3:0] r;
      r = 4'b0000;
      if (v[3])      r = 4'b1000;
      else if (v[2]) r = 4'b0100;
      else if (v[1]) r = 4'b0010;
      else if (v[0]) r = 4'b0001;
      return r;
   endfunction

   function automatic logic [7:0] enc(input logic [3:0] oh);
      logic [7:0] r;
      r = 8'h00;
      unique case (1'b1)
         oh[3]:   r = KEY_W;
         oh[2]:   r = KEY_A;
         oh[1]:   r = KEY_S;
         oh[0]:   r = KEY_D;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic hit(input logic [7:0] code,
                                input logic [7:0] k0, input logic [7:0] k1,
                                input logic [7:0] k2, input logic [7:0] k3);
      return (k0 == code) || (k1 == code) || (k2 == code) || (k3 == code);
   endfunction

   always_comb begin
      pressed_d    = pressed_q;
      active_d     = active_q;
      tap_d        = tap_q;
      keycode_d    = keycode_q;
      hold_d       = hold_q;
      tap_set      = 1'b0;
      newly        = 4'b0000;
      kc_nx        = 8'h00;

      rollover = (key0 == 8'h01) && (key1 == 8'h01) &&
                 (key2 == 8'h01) && (key3 == 8'h01);
      pressed_nx = {hit(KEY_W, key0, key1, key2, key3),
                    hit(KEY_A, key0, key1, key2, key3),
                    hit(KEY_S, key0, key1, key2, key3),
                    hit(KEY_D, key0, key1, key2, key3)};

      if (report_valid && !rollover) begin
         newly     = pressed_nx & ~pressed_q;
         pressed_d = pressed_nx;
         if (|newly) begin
            active_d = pick(newly);
            tap_d    = pick(newly);
            tap_set  = 1'b1;
         end else if (~|(active_q & pressed_nx)) begin
            active_d = pick(pressed_nx);
         end
      end

      // armed blocks a spurious tick when vs is already high out of reset
      tick         = vs & ~vs_q & armed_q;
      frame_tick_d = tick;
      vs_d         = vs;
      armed_d      = armed_q | ~vs;

      if (tick) begin
         if (|active_q)   kc_nx = enc(active_q);
         else if (|tap_q) kc_nx = enc(tap_q);
         else             kc_nx = 8'h00;
         if (!tap_set) tap_d = 4'b0000;
         keycode_d = kc_nx;
         if ((kc_nx == keycode_q) && (kc_nx != 8'h00))
            hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
         else
            hold_d = 8'h00;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pressed_q    <= 4'b0000;
         active_q     <= 4'b0000;
         tap_q        <= 4'b0000;
         keycode_q    <= 8'h00;
         hold_q       <= 8'h00;
         frame_tick_q <= 1'b0;
         vs_q         <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         pressed_q    <= pressed_d;
         active_q     <= active_d;
         tap_q        <= tap_d;
         keycode_q    <= keycode_d;
         hold_q       <= hold_d;
         frame_tick_q <= frame_tick_d;
         vs_q         <= vs_d;
         armed_q      <= armed_d;
      end
   end

   assign keycode     = keycode_q;
   assign frame_tick  = frame_tick_q;
   assign hold_frames = hold_q;

endmodule

// File: tb/tb_key_dir_arbiter.sv
// Directed bench for key_dir_arbiter: frame resolution, taps, rollover,
// hold saturation, same-cycle report/tick and reset behaviour.
module tb_key_dir_arbiter;

   logic       Clk;
   logic       Reset;
   logic       report_valid;
   logic [7:0] key0, key1, key2, key3;
   logic       vs;
   logic [7:0] keycode;
   logic       frame_tick;
   logic [7:0] hold_frames;

   int n_total;
   int n_pass;

   key_dir_arbiter dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .report_valid (report_valid),
      .key0         (key0),
      .key1         (key1),
      .key2         (key2),
      .key3         (key3),
      .vs           (vs),
      .keycode      (keycode),
      .frame_tick   (frame_tick),
      .hold_frames  (hold_frames)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic report(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
      report_valid = 1'b1;
      key0 = a; key1 = b; key2 = c; key3 = d;
      step();
      report_valid = 1'b0;
      key0 = 8'h00; key1 = 8'h00; key2 = 8'h00; key3 = 8'h00;
   endtask

   task automatic tick_frame();
      vs = 1'b1;
      step();
      vs = 1'b0;
      step();
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      Reset = 1'b1;
      report_valid = 1'b0;
      key0 = 8'h00; key1 = 8'h00; key2 = 8'h00; key3 = 8'h00;
      vs = 1'b0;
      step();
      step();
      chk("rst_keycode", keycode, 8'h00);
      chk("rst_tick", {7'd0, frame_tick}, 8'h00);
      chk("rst_hold", hold_frames, 8'h00);
      Reset = 1'b0;
      step();

      // A pressed, first tick
      report(8'h04, 8'h00, 8'h00, 8'h00);
      chk("a_between", keycode, 8'h00);
      vs = 1'b1;
      step();
      chk("a_tick_pulse", {7'd0, frame_tick}, 8'h01);
      chk("a_keycode", keycode, 8'h04);
      chk("a_hold0", hold_frames, 8'h00);
      vs = 1'b0;
      step();
      chk("a_tick_low", {7'd0, frame_tick}, 8'h00);
      tick_frame();
      chk("a_hold1", hold_frames, 8'h01);
      chk("a_keep", keycode, 8'h04);

      // W added wins, then release W falls back to A
      report(8'h04, 8'h1A, 8'h00, 8'h00);
      chk("w_between", keycode, 8'h04);
      chk("w_hold_between", hold_frames, 8'h01);
      tick_frame();
      chk("w_keycode", keycode, 8'h1A);
      chk("w_hold0", hold_frames, 8'h00);
      report(8'h04, 8'h00, 8'h00, 8'h00);
      tick_frame();
      chk("fallback_a", keycode, 8'h04);
      chk("fallback_hold", hold_frames, 8'h00);
      report(8'h00, 8'h00, 8'h00, 8'h00);
      tick_frame();
      chk("release_all", keycode, 8'h00);

      // short tap of D between two ticks
      report(8'h07, 8'h00, 8'h00, 8'h00);
      report(8'h00, 8'h00, 8'h00, 8'h00);
      tick_frame();
      chk("tap_d", keycode, 8'h07);
      tick_frame();
      chk("tap_gone", keycode, 8'h00);
      chk("tap_gone_hold", hold_frames, 8'h00);

      // hold S, rollover report ignored, saturation
      report(8'h00, 8'h16, 8'h16, 8'h00);
      tick_frame();
      chk("s_keycode", keycode, 8'h16);
      tick_frame();
      chk("s_hold1", hold_frames, 8'h01);
      report(8'h01, 8'h01, 8'h01, 8'h01);
      tick_frame();
      chk("rollover_key", keycode, 8'h16);
      chk("rollover_hold", hold_frames, 8'h02);
      for (int i = 0; i < 252; i++) tick_frame();
      chk("hold_254", hold_frames, 8'hFE);
      tick_frame();
      chk("hold_255", hold_frames, 8'hFF);
      for (int i = 0; i < 44; i++) tick_frame();
      chk("hold_sat", hold_frames, 8'hFF);
      chk("hold_sat_key", keycode, 8'h16);

      // report and vs rise in the same cycle: tick uses the old state
      report_valid = 1'b1;
      key0 = 8'h16; key1 = 8'h07; key2 = 8'h00; key3 = 8'h00;
      vs = 1'b1;
      step();
      report_valid = 1'b0;
      key0 = 8'h00; key1 = 8'h00;
      chk("same_cyc_tick", {7'd0, frame_tick}, 8'h01);
      chk("same_cyc_old", keycode, 8'h16);
      chk("same_cyc_hold", hold_frames, 8'hFF);
      vs = 1'b0;
      step();
      tick_frame();
      chk("same_cyc_next", keycode, 8'h07);
      chk("same_cyc_next_hold", hold_frames, 8'h00);

      // reset mid-frame, together with a report
      report_valid = 1'b1;
      key0 = 8'h1A;
      Reset = 1'b1;
      step();
      report_valid = 1'b0;
      key0 = 8'h00;
      chk("midrst_key", keycode, 8'h00);
      chk("midrst_hold", hold_frames, 8'h00);
      chk("midrst_tick", {7'd0, frame_tick}, 8'h00);
      Reset = 1'b0;
      step();
      tick_frame();
      chk("midrst_report_lost", keycode, 8'h00);

      // vs already high at reset release: no tick until low then high
      Reset = 1'b1;
      vs = 1'b1;
      step();
      Reset = 1'b0;
      step();
      chk("arm_no_tick0", {7'd0, frame_tick}, 8'h00);
      report(8'h1A, 8'h00, 8'h00, 8'h00);
      chk("arm_no_tick1", {7'd0, frame_tick}, 8'h00);
      chk("arm_key_held", keycode, 8'h00);
      vs = 1'b0;
      step();
      vs = 1'b1;
      step();
      chk("arm_tick", {7'd0, frame_tick}, 8'h01);
      chk("arm_keycode", keycode, 8'h1A);
      vs = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
